// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared state type and level constants for the LED blink controller
package led_blink_pkg;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } blink_state_t;

endpackage

// File: rtl/led_blink_pulse_stretch.sv
// rtl/led_blink_pulse_stretch.sv - retriggerable stretcher: Q high for CYCLES cycles after the last TRIG
module pulse_stretch #(
  parameter int CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic TRIG,
  output logic Q
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (TRIG) begin
      cnt <= CNT_W'(CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Q comes straight from the counter so an asynchronous reset clears it at once.
  assign Q = (cnt != '0);

endmodule

// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - press-driven variable-rate LED blinker with pause and ACK stretch
// Optional: define LED_BLINK_WRAP_EN to make the speed level wrap instead of saturate.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int HALF_PERIOD_MAX = 62_500_000,
  parameter int ACK_CYCLES      = 12_500_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_UP,
  input  logic               BTN_DOWN,
  output logic               LED,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic               PAUSED,
  output logic               ACK
);

  localparam int CNT_W = $clog2(HALF_PERIOD_MAX + 1);
  localparam logic [CNT_W-1:0] HP_MAX = CNT_W'(HALF_PERIOD_MAX);

  blink_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             both;
  logic             up_ok;
  logic             dn_ok;
  logic             level_chg;
  logic             accept;

  assign limit = HP_MAX >> LEVEL;
  assign both  = BTN_UP & BTN_DOWN;

`ifdef LED_BLINK_WRAP_EN
  assign up_ok = BTN_UP & ~BTN_DOWN & (state == RUN);
  assign dn_ok = BTN_DOWN & ~BTN_UP & (state == RUN);
`else
  assign up_ok = BTN_UP & ~BTN_DOWN & (state == RUN) & (LEVEL != LEVEL_MAX);
  assign dn_ok = BTN_DOWN & ~BTN_UP & (state == RUN) & (LEVEL != '0);
`endif

  assign level_chg = up_ok | dn_ok;
  assign accept    = both | level_chg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else if (both) begin
      state <= (state == RUN) ? HOLD : RUN;
    end
  end

  // Level arithmetic is modulo 8, which gives the wrap behaviour for free.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LEVEL <= '0;
    end else if (up_ok) begin
      LEVEL <= LEVEL + LEVEL_W'(1);
    end else if (dn_ok) begin
      LEVEL <= LEVEL - LEVEL_W'(1);
    end
  end

  // A level change restarts the half-period but leaves LED alone to avoid a glitch toggle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      LED <= 1'b0;
    end else if (level_chg) begin
      cnt <= '0;
    end else if (state == RUN) begin
      if (cnt == limit - CNT_W'(1)) begin
        cnt <= '0;
        LED <= ~LED;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign PAUSED = (state == HOLD);

  pulse_stretch #(
    .CYCLES(ACK_CYCLES)
  ) u_ack (
    .CLK (CLK),
    .RST (RST),
    .TRIG(accept),
    .Q   (ACK)
  );

endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb/tb_led_blink_ctrl.sv - vector table, corner sequences and randomized model check for led_blink_ctrl
module tb_led_blink_ctrl;

  localparam int HP  = 256;
  localparam int ACKC = 4;
`ifdef LED_BLINK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_UP = 1'b0;
  logic       BTN_DOWN = 1'b0;
  logic       LED;
  logic [2:0] LEVEL;
  logic       PAUSED;
  logic       ACK;

  int n_cmp = 0;
  int n_fail = 0;

  int m_level, m_phase, m_ack_rem;
  bit m_paused, m_led;

  typedef struct {
    logic up;
    logic dn;
    int   lvl;
    logic paused;
    logic ack;
  } vec_t;

  vec_t vecs[16];

  led_blink_ctrl #(
    .HALF_PERIOD_MAX(HP),
    .ACK_CYCLES     (ACKC)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_UP  (BTN_UP),
    .BTN_DOWN(BTN_DOWN),
    .LED     (LED),
    .LEVEL   (LEVEL),
    .PAUSED  (PAUSED),
    .ACK     (ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_clear();
    m_level = 0; m_phase = 0; m_ack_rem = 0; m_paused = 0; m_led = 0;
  endtask

  // Behaviour of one clock edge, phrased as press rules plus an elapsed-cycle count.
  task automatic model_edge(input bit up, input bit dn);
    bit run, upok, dnok;
    run  = !m_paused;
    upok = run && up && !dn && (m_level < 7 || WRAP);
    dnok = run && dn && !up && (m_level > 0 || WRAP);
    if (upok) m_level = (m_level + 1) % 8;
    else if (dnok) m_level = (m_level + 7) % 8;
    if (upok || dnok) m_phase = 0;
    else if (run) begin
      m_phase++;
      if (m_phase >= (HP >> m_level)) begin
        m_phase = 0;
        m_led = !m_led;
      end
    end
    if (up && dn) m_paused = !m_paused;
    if ((up && dn) || upok || dnok) m_ack_rem = ACKC;
    else if (m_ack_rem > 0) m_ack_rem--;
  endtask

  task automatic tick(input logic up, input logic dn);
    BTN_UP = up;
    BTN_DOWN = dn;
    @(posedge CLK);
    model_edge(up, dn);
    #1;
    BTN_UP = 1'b0;
    BTN_DOWN = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    BTN_UP = 1'b0;
    BTN_DOWN = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_clear();
  endtask

  task automatic fill_vecs();
    vecs[0]  = '{1'b1, 1'b0, 1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 2, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 0, 1'b0, 1'b0};
  endtask

  initial begin
    int cnt, r;
    bit ack_seen, led0;

    fill_vecs();
    do_reset();

    check("reset_led", LED, 0);
    check("reset_level", LEVEL, 0);
    check("reset_paused", PAUSED, 0);
    check("reset_ack", ACK, 0);

    // Free-running blink at level 0.
    ack_seen = 0;
    for (int i = 0; i < 255; i++) begin
      tick(1'b0, 1'b0);
      if (ACK) ack_seen = 1;
    end
    check("blink_before_256", LED, 0);
    tick(1'b0, 1'b0);
    check("blink_at_256", LED, 1);
    for (int i = 0; i < 255; i++) begin
      tick(1'b0, 1'b0);
      if (ACK) ack_seen = 1;
    end
    check("blink_before_512", LED, 1);
    tick(1'b0, 1'b0);
    check("blink_at_512", LED, 0);
    check("idle_ack_never", ack_seen, 0);
    check("idle_level", LEVEL, 0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].up, vecs[i].dn);
      check($sformatf("vec%0d_level", i), LEVEL, vecs[i].lvl);
      check($sformatf("vec%0d_paused", i), PAUSED, vecs[i].paused);
      check($sformatf("vec%0d_ack", i), ACK, vecs[i].ack);
    end

    // Three spaced ups: isolated ACK width and new half-period from the last press.
    do_reset();
    tick(1'b1, 1'b0);
    cnt = ACK ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b0);
      if (ACK) cnt++;
    end
    check("ack_width_isolated", cnt, 4);
    tick(1'b1, 1'b0);
    idle(9);
    tick(1'b1, 1'b0);
    check("three_ups_level", LEVEL, 3);
    led0 = LED;
    cnt = 0;
    while (LED == led0 && cnt < 100) begin
      tick(1'b0, 1'b0);
      cnt++;
    end
    check("level3_first_toggle", cnt, 32);
    cnt = 0;
    led0 = LED;
    while (LED == led0 && cnt < 100) begin
      tick(1'b0, 1'b0);
      cnt++;
    end
    check("level3_half_period", cnt, 32);

    // Down at level 0, then up at level 7.
    do_reset();
    tick(1'b0, 1'b1);
    check("down_at_0_level", LEVEL, WRAP ? 7 : 0);
    check("down_at_0_ack", ACK, WRAP ? 1 : 0);
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
    idle(5);
    check("reach_7_level", LEVEL, 7);
    check("reach_7_ack_off", ACK, 0);
    tick(1'b1, 1'b0);
    check("up_at_7_level", LEVEL, WRAP ? 0 : 7);
    check("up_at_7_ack", ACK, WRAP ? 1 : 0);

    // Pause freezes LED and count; resume continues from the held count.
    do_reset();
    idle(100);
    tick(1'b1, 1'b1);
    check("pause_paused", PAUSED, 1);
    led0 = LED;
    idle(20);
    tick(1'b1, 1'b0);
    check("pause_up_ignored", LEVEL, 0);
    idle(300);
    check("pause_led_frozen", LED, led0);
    tick(1'b1, 1'b1);
    check("resume_paused", PAUSED, 0);
    idle(154);
    check("resume_before_toggle", LED, 0);
    tick(1'b0, 1'b0);
    check("resume_toggle", LED, 1);

    // Retrigger: two accepted presses two cycles apart.
    do_reset();
    tick(1'b1, 1'b0);
    cnt = ACK ? 1 : 0;
    tick(1'b0, 1'b0);
    if (ACK) cnt++;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 20 && ACK; i++) begin
      cnt++;
      tick(1'b0, 1'b0);
    end
    check("ack_retrigger_width", cnt, 6);

    // Asynchronous reset mid-cycle with LED high, level 5, ACK high.
    do_reset();
    idle(300);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check("pre_rst_level", LEVEL, 5);
    check("pre_rst_ack", ACK, 1);
    check("pre_rst_led", LED, 1);
    #3;
    RST = 1'b1;
    #1;
    check("async_rst_led", LED, 0);
    check("async_rst_level", LEVEL, 0);
    check("async_rst_paused", PAUSED, 0);
    check("async_rst_ack", ACK, 0);

    // Randomized presses against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) tick(1'b1, 1'b1);
      else if (r < 6) tick(1'b1, 1'b0);
      else if (r < 11) tick(1'b0, 1'b1);
      else tick(1'b0, 1'b0);
      check($sformatf("rnd%0d_level", i), LEVEL, m_level);
      check($sformatf("rnd%0d_paused", i), PAUSED, m_paused);
      check($sformatf("rnd%0d_ack", i), ACK, (m_ack_rem > 0) ? 1 : 0);
      check($sformatf("rnd%0d_led", i), LED, m_led);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
